// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache refill controller.
// Contents:
//   - default widths and refill policy limits
//   - controller state enum (3-bit)
//   - performance counter bundle (used when ICACHE_PERF_CNT_EN is defined)
//   - counter width helper
package icache_pkg;

  localparam int unsigned IC_ADDR_W      = 20;
  localparam int unsigned IC_DATA_W      = 32;
  localparam int unsigned IC_TIMEOUT_CYC = 255;
  localparam int unsigned IC_MAX_RETRY   = 3;
  localparam int unsigned PERF_CNT_W     = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    FILL     = 3'd4,
    ERROR    = 3'd5
  } ic_state_e;

  typedef struct packed {
    logic [PERF_CNT_W-1:0] hits;
    logic [PERF_CNT_W-1:0] misses;
    logic [PERF_CNT_W-1:0] stall_cyc;
  } ic_perf_cnt_t;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/icache_perf_cnt.sv
// Saturating hit / miss / stall-cycle counters for the refill controller.
// Ports:
//   CLK, RST  clock and asynchronous active-high reset
//   i_hit     lookup hit this cycle
//   i_miss    lookup miss this cycle
//   i_stall   fetch stall asserted this cycle
//   o_cnt     counter bundle (hits, misses, stall_cyc)
module icache_perf_cnt
  import icache_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_hit,
  input  logic         i_miss,
  input  logic         i_stall,
  output ic_perf_cnt_t o_cnt
);

  localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

  ic_perf_cnt_t r_cnt;

  // Increment when enabled, holding at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v,
                                                    input logic en);
    return (en && (v != CNT_MAX)) ? v + PERF_CNT_W'(1) : v;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else begin
      r_cnt.hits      <= sat_inc(r_cnt.hits, i_hit);
      r_cnt.misses    <= sat_inc(r_cnt.misses, i_miss);
      r_cnt.stall_cyc <= sat_inc(r_cnt.stall_cyc, i_stall);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache sequencer for the fetch stage: accepts fetch requests,
// drives the cache lookup, refills misses from backing memory with a
// timeout/retry policy, and raises a sticky error when retries run out.
// Optional build macro: ICACHE_PERF_CNT_EN adds perf_hits / perf_misses /
// perf_stall_cyc saturating counters.
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   cpu_req/cpu_addr            fetch request in
//   cpu_ready/cpu_rdata         word delivered
//   cpu_stall/cpu_err           fetch hold / sticky error
//   ic_read_en/ic_addr          cache lookup
//   ic_miss/ic_rdata            cache lookup result (combinational)
//   ic_fetch/ic_wdata           cache fill strobe and data
//   mem_req/mem_addr            backing-memory read request (level)
//   mem_ack/mem_rdata           memory response (single-cycle)
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W      = IC_ADDR_W,
  parameter int unsigned DATA_W      = IC_DATA_W,
  parameter int unsigned TIMEOUT_CYC = IC_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY   = IC_MAX_RETRY
)(
  input  logic              CLK,
  input  logic              RST,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_stall_cyc,
`endif
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              ic_read_en,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_miss,
  input  logic [DATA_W-1:0] ic_rdata,
  output logic              ic_fetch,
  output logic [DATA_W-1:0] ic_wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TMR_W = cnt_width(TIMEOUT_CYC);
  localparam int unsigned RTY_W = cnt_width(MAX_RETRY);
  localparam logic [TMR_W-1:0] TMR_MAX = '1;

  ic_state_e         r_state;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_stall;
  logic              r_cpu_err;
  logic              r_ic_read_en;
  logic [ADDR_W-1:0] r_ic_addr;
  logic              r_ic_fetch;
  logic [DATA_W-1:0] r_ic_wdata;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [TMR_W-1:0]  r_timer;
  logic [RTY_W-1:0]  r_retry;

  logic [TMR_W-1:0]  w_timer_inc;
  logic              w_timeout;

  // Wait timer saturates; expiry is judged on the value it would take this cycle.
  assign w_timer_inc = (r_timer == TMR_MAX) ? r_timer : r_timer + TMR_W'(1);
  assign w_timeout   = (w_timer_inc >= TMR_W'(TIMEOUT_CYC));

  // Controller FSM with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cpu_ready  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_stall  <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_ic_read_en <= 1'b0;
      r_ic_addr    <= '0;
      r_ic_fetch   <= 1'b0;
      r_ic_wdata   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_timer      <= '0;
      r_retry      <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_ic_fetch  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_ic_addr    <= cpu_addr;
            r_ic_read_en <= 1'b1;
            r_state      <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (!ic_miss) begin
            r_cpu_ready <= 1'b1;
            r_cpu_rdata <= ic_rdata;
            if (cpu_req) begin
              r_ic_addr <= cpu_addr;
            end else begin
              r_ic_read_en <= 1'b0;
              r_state      <= IDLE;
            end
          end else begin
            // Address and read enable are frozen until the fill completes.
            r_cpu_stall <= 1'b1;
            r_retry     <= '0;
            r_timer     <= '0;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= {r_ic_addr[ADDR_W-1:2], 2'b00};
            r_state     <= MEM_REQ;
          end
        end

        MEM_REQ: begin
          r_mem_req <= 1'b1;
          r_timer   <= '0;
          r_state   <= MEM_WAIT;
        end

        MEM_WAIT: begin
          r_timer <= w_timer_inc;
          // An ack arriving on the expiry cycle still wins.
          if (mem_ack) begin
            r_ic_wdata  <= mem_rdata;
            r_cpu_rdata <= mem_rdata;
            r_mem_req   <= 1'b0;
            r_ic_fetch  <= 1'b1;
            r_cpu_ready <= 1'b1;
            r_cpu_stall <= 1'b0;
            r_state     <= FILL;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RTY_W'(1);
              r_timer <= '0;
              r_state <= MEM_REQ;
            end else begin
              r_cpu_err <= 1'b1;
              r_state   <= ERROR;
            end
          end
        end

        FILL: begin
          r_ic_read_en <= 1'b0;
          r_state      <= IDLE;
        end

        ERROR: begin
          r_cpu_err   <= 1'b1;
          r_cpu_stall <= 1'b1;
          r_mem_req   <= 1'b0;
        end

        default: begin
          r_cpu_stall  <= 1'b0;
          r_ic_read_en <= 1'b0;
          r_mem_req    <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = r_cpu_ready;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_stall  = r_cpu_stall;
  assign cpu_err    = r_cpu_err;
  assign ic_read_en = r_ic_read_en;
  assign ic_addr    = r_ic_addr;
  assign ic_fetch   = r_ic_fetch;
  assign ic_wdata   = r_ic_wdata;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;

`ifdef ICACHE_PERF_CNT_EN
  logic         w_lookup_hit;
  logic         w_lookup_miss;
  ic_perf_cnt_t w_perf;

  assign w_lookup_hit  = (r_state == LOOKUP) && !ic_miss;
  assign w_lookup_miss = (r_state == LOOKUP) && ic_miss;

  icache_perf_cnt u_perf_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_hit   (w_lookup_hit),
    .i_miss  (w_lookup_miss),
    .i_stall (r_cpu_stall),
    .o_cnt   (w_perf)
  );

  assign perf_hits      = w_perf.hits;
  assign perf_misses    = w_perf.misses;
  assign perf_stall_cyc = w_perf.stall_cyc;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: plays fetch unit, cache and memory; checks
// directed vectors, multi-cycle corner sequences and random transactions
// against a transaction-level cache/latency model.
module tb_icache_refill_ctrl;

  localparam int unsigned AW   = 20;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 8;
  localparam int unsigned RTRY = 1;

  logic          CLK;
  logic          RST;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          cpu_err;
  logic          ic_read_en;
  logic [AW-1:0] ic_addr;
  logic          ic_miss;
  logic [DW-1:0] ic_rdata;
  logic          ic_fetch;
  logic [DW-1:0] ic_wdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;
  logic [31:0]   perf_stall_cyc;
`endif

  int n_vec = 0;
  int n_err = 0;

  icache_refill_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (RTRY)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
`ifdef ICACHE_PERF_CNT_EN
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ready      (cpu_ready),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .cpu_err        (cpu_err),
    .ic_read_en     (ic_read_en),
    .ic_addr        (ic_addr),
    .ic_miss        (ic_miss),
    .ic_rdata       (ic_rdata),
    .ic_fetch       (ic_fetch),
    .ic_wdata       (ic_wdata),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          miss;
    logic [DW-1:0] cword;
    logic [DW-1:0] mword;
    int            k;
    logic          withhold;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_maddr;
    int            exp_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Stall length of one refill: the request cycle plus every wait cycle up to
  // the ack; a withheld first attempt adds a full timeout and one idle gap.
  function automatic int exp_stall_f(input int k, input logic withhold);
    return withhold ? int'(TMO) + k + 3 : k + 1;
  endfunction

  // One fetch transaction. k: ack comes k cycles after mem_req rises on the
  // answered attempt. withhold: the first memory request is never answered.
  task automatic do_fetch(input logic [AW-1:0] addr, input logic miss,
                          input logic [DW-1:0] cword, input logic [DW-1:0] mword,
                          input int k, input logic withhold,
                          input logic [DW-1:0] exp_data, input logic [AW-1:0] exp_maddr,
                          input int exp_stall);
    int   stall_cnt, gaps, h, fetches;
    logic prev_req, done, bad_hold, retried;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    ic_miss  = miss;
    ic_rdata = cword;
    mem_ack  = 1'b0;
    tick();
    cpu_req  = 1'b0;
    cpu_addr = AW'($urandom);
    chk("accept_ic_addr", 32'(ic_addr), 32'(addr));
    chk("accept_read_en", 32'(ic_read_en), 32'd1);
    // Stray ack outside the wait window must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0000;
    tick();
    mem_ack = 1'b0;
    if (!miss) begin
      chk("hit_ready", 32'(cpu_ready), 32'd1);
      chk("hit_rdata", cpu_rdata, exp_data);
      chk("hit_no_stall", 32'(cpu_stall), 32'd0);
      chk("hit_no_memreq", 32'(mem_req), 32'd0);
      tick();
      chk("hit_done_ready", 32'(cpu_ready), 32'd0);
      chk("hit_done_read_en", 32'(ic_read_en), 32'd0);
    end else begin
      chk("miss_ready_low", 32'(cpu_ready), 32'd0);
      chk("miss_memreq", 32'(mem_req), 32'd1);
      chk("miss_mem_addr", 32'(mem_addr), 32'(exp_maddr));
      stall_cnt = 0; gaps = 0; h = 0; fetches = 0;
      prev_req = 1'b0; done = 1'b0; bad_hold = 1'b0; retried = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
        if (cpu_ready) begin
          done = 1'b1;
        end else begin
          if (cpu_stall) stall_cnt++;
          if (ic_addr !== addr || ic_read_en !== 1'b1) bad_hold = 1'b1;
          if (ic_fetch) fetches++;
          if (mem_req) begin
            h++;
          end else begin
            if (prev_req) gaps++;
            h = 0;
            retried = 1'b1;
          end
          prev_req  = mem_req;
          mem_ack   = mem_req && (h == k + 1) && !(withhold && !retried);
          mem_rdata = mem_ack ? mword : $urandom;
          tick();
          mem_ack = 1'b0;
        end
      end
      chk("fill_seen", 32'(done), 32'd1);
      chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
      chk("memreq_gaps", 32'(gaps), withhold ? 32'd1 : 32'd0);
      chk("addr_held", 32'(bad_hold), 32'd0);
      chk("early_fetch", 32'(fetches), 32'd0);
      chk("fill_strobe", 32'(ic_fetch), 32'd1);
      chk("fill_wdata", ic_wdata, mword);
      chk("fill_rdata", cpu_rdata, exp_data);
      chk("fill_stall_low", 32'(cpu_stall), 32'd0);
      chk("fill_memreq_low", 32'(mem_req), 32'd0);
      chk("fill_err_low", 32'(cpu_err), 32'd0);
      tick();
      chk("post_fill_strobe", 32'(ic_fetch), 32'd0);
      chk("post_fill_ready", 32'(cpu_ready), 32'd0);
      chk("post_fill_read_en", 32'(ic_read_en), 32'd0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_cpu_err"}, 32'(cpu_err), 32'd0);
    chk({tag, "_ic_read_en"}, 32'(ic_read_en), 32'd0);
    chk({tag, "_ic_addr"}, 32'(ic_addr), 32'd0);
    chk({tag, "_ic_fetch"}, 32'(ic_fetch), 32'd0);
    chk({tag, "_ic_wdata"}, ic_wdata, 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Transaction-level cache model for random traffic.
  logic          mdl_valid [8];
  logic [DW-1:0] mdl_data  [8];

  initial begin
    int            cyc_err, fetch_seen, idx, k;
    logic          wh, miss;
    logic [AW-1:0] a;
    logic [DW-1:0] mw;

    vecs[0] = '{20'h00010, 1'b0, 32'h00B7_0000, 32'h0,          0, 1'b0, 32'h00B7_0000, 20'h00000, 0};
    vecs[1] = '{20'h00413, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF,  5, 1'b0, 32'hDEAD_BEEF, 20'h00410, 6};
    vecs[2] = '{20'h00C02, 1'b1, 32'h2222_2222, 32'h1234_5678,  2, 1'b1, 32'h1234_5678, 20'h00C00, 13};
    vecs[3] = '{20'h7FFFF, 1'b1, 32'h3333_3333, 32'hCAFE_F00D,  8, 1'b0, 32'hCAFE_F00D, 20'h7FFFC, 9};
    vecs[4] = '{20'hFFFFF, 1'b0, 32'hA5A5_5A5A, 32'h0,          0, 1'b0, 32'hA5A5_5A5A, 20'h00000, 0};
    vecs[5] = '{20'h00001, 1'b1, 32'h4444_4444, 32'h0000_0001,  1, 1'b0, 32'h0000_0001, 20'h00000, 2};

    RST = 1'b1; cpu_req = 1'b0; cpu_addr = '0; ic_miss = 1'b0; ic_rdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    chk_reset_state("rst");
    RST = 1'b0;
    tick();
    chk_reset_state("idle");

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i].addr, vecs[i].miss, vecs[i].cword, vecs[i].mword, vecs[i].k,
               vecs[i].withhold, vecs[i].exp_data, vecs[i].exp_maddr, vecs[i].exp_stall);
    end

    // Back-to-back hits: one word per cycle while cpu_req stays high.
    ic_miss = 1'b0;
    cpu_req = 1'b1; cpu_addr = 20'h00010;
    tick();
    cpu_addr = 20'h00014; ic_rdata = 32'hB0B0_0010;
    tick();
    chk("b2b_ready0", 32'(cpu_ready), 32'd1);
    chk("b2b_rdata0", cpu_rdata, 32'hB0B0_0010);
    chk("b2b_addr1", 32'(ic_addr), 32'h00014);
    cpu_addr = 20'h00018; ic_rdata = 32'hB0B0_0014;
    tick();
    chk("b2b_ready1", 32'(cpu_ready), 32'd1);
    chk("b2b_rdata1", cpu_rdata, 32'hB0B0_0014);
    chk("b2b_addr2", 32'(ic_addr), 32'h00018);
    cpu_req = 1'b0; ic_rdata = 32'hB0B0_0018;
    tick();
    chk("b2b_ready2", 32'(cpu_ready), 32'd1);
    chk("b2b_rdata2", cpu_rdata, 32'hB0B0_0018);
    tick();
    chk("b2b_end_ready", 32'(cpu_ready), 32'd0);
    chk("b2b_end_read_en", 32'(ic_read_en), 32'd0);

    // Error: memory never answers; retries run out after 2*(TMO+2) cycles.
    cpu_req = 1'b1; cpu_addr = 20'h00200; ic_miss = 1'b1;
    cyc_err = 0; fetch_seen = 0;
    for (int n = 1; n <= 80 && cyc_err == 0; n++) begin
      tick();
      cpu_req = 1'b0;
      if (ic_fetch) fetch_seen++;
      if (cpu_err) cyc_err = n;
    end
    chk("err_latency", 32'(cyc_err), 32'(2 * (TMO + 2)));
    chk("err_memreq_low", 32'(mem_req), 32'd0);
    chk("err_stall", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b1;
    mem_ack = 1'b1;
    repeat (5) begin
      tick();
      if (ic_fetch) fetch_seen++;
    end
    mem_ack = 1'b0; cpu_req = 1'b0;
    chk("err_sticky", 32'(cpu_err), 32'd1);
    chk("err_no_ready", 32'(cpu_ready), 32'd0);
    chk("err_no_memreq", 32'(mem_req), 32'd0);
    chk("err_no_fetch", 32'(fetch_seen), 32'd0);
    pulse_reset();
    chk("err_cleared", 32'(cpu_err), 32'd0);
    chk("err_stall_cleared", 32'(cpu_stall), 32'd0);

    // Reset in the middle of a refill drops mem_req without waiting for a clock.
    cpu_req = 1'b1; cpu_addr = 20'h00530; ic_miss = 1'b1;
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();
    chk("midrst_memreq_before", 32'(mem_req), 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("midrst_memreq_async", 32'(mem_req), 32'd0);
    chk("midrst_stall_async", 32'(cpu_stall), 32'd0);
    chk("midrst_fetch", 32'(ic_fetch), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk_reset_state("midrst");
    do_fetch(20'h00530, 1'b1, 32'h5555_5555, 32'h0BAD_F00D, 3, 1'b0,
             32'h0BAD_F00D, 20'h00530, exp_stall_f(3, 1'b0));

    // Random traffic against the cache model.
    for (int i = 0; i < 8; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_data[i]  = '0;
    end
    for (int t = 0; t < 40; t++) begin
      idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) mdl_valid[idx] = 1'b0;
      a    = AW'(32'h20000 + 32'(idx) * 4 + $urandom_range(0, 3));
      miss = !mdl_valid[idx];
      wh   = miss && ($urandom_range(0, 4) == 0);
      k    = wh ? int'($urandom_range(1, TMO - 2)) : int'($urandom_range(1, TMO));
      mw   = $urandom;
      do_fetch(a, miss, mdl_data[idx], mw, k, wh,
               miss ? mw : mdl_data[idx], a & 20'hFFFFC, miss ? exp_stall_f(k, wh) : 0);
      if (miss) begin
        mdl_valid[idx] = 1'b1;
        mdl_data[idx]  = mw;
      end
    end

`ifdef ICACHE_PERF_CNT_EN
    pulse_reset();
    do_fetch(20'h00100, 1'b0, 32'h1, 32'h0, 0, 1'b0, 32'h1, 20'h0, 0);
    do_fetch(20'h00104, 1'b0, 32'h2, 32'h0, 0, 1'b0, 32'h2, 20'h0, 0);
    do_fetch(20'h00108, 1'b0, 32'h3, 32'h0, 0, 1'b0, 32'h3, 20'h0, 0);
    do_fetch(20'h0010C, 1'b1, 32'h0, 32'h6666_6666, 5, 1'b0, 32'h6666_6666, 20'h0010C,
             exp_stall_f(5, 1'b0));
    chk("perf_hits", perf_hits, 32'd3);
    chk("perf_misses", perf_misses, 32'd1);
    chk("perf_stall_cyc", perf_stall_cyc, 32'(exp_stall_f(5, 1'b0)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
